seq_word_calculator: RTL

Parametrised successor to the byte calculator: a WIDTH-bit, four-function integer ALU (add, subtract, multiply, divide) plus clear. Add, subtract and clear complete in one cycle. Multiply uses a multi-cycle shift-add datapath and divide uses a restoring datapath. The block sits behind the board's debounced-button/switch front end and drives the LED/display result. It uses a start/busy/done handshake so the top level can launch operations from single-cycle button pulses.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/seq_word_calculator_if.sv | 28 ++
 rtl/mul_div_iter.sv | 87 ++++++++
 rtl/seq_word_calculator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for seq_word_calculator: op codes, FSM encoding and
// the start-to-done latency of each operation.
package calc_pkg;

  localparam logic [2:0] OP_CLEAR = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_ITER   = 2'd2,
    ST_FINISH = 2'd3
  } calc_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_DIV);
  endfunction

  // Edges from the accepting edge to the edge that raises done; 0 means the
  // op code is reserved and never completes.
  function automatic int unsigned calc_latency(input logic [2:0] op,
                                               input logic b_is_zero,
                                               input int unsigned width);
    if (!op_is_valid(op)) return 0;
    if (op == OP_MUL || (op == OP_DIV && !b_is_zero)) return width + 2;
    return 1;
  endfunction

endpackage

// File: rtl/seq_word_calculator_if.sv
// Request/response bundle between the board front end and the calculator.
// Handshake: start is taken only on an edge where busy=0 and op is legal; done
// pulses for one cycle when result/carry/div_by_zero update, busy is low then.
interface seq_word_calculator_if #(
  parameter int WIDTH = 8
);

  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     operand_a;
  logic [WIDTH-1:0]     operand_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 carry;
  logic                 div_by_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, result, carry, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, result, carry, div_by_zero
  );

endinterface

// File: rtl/mul_div_iter.sv
// Shared iterative datapath: one 2*WIDTH shift register, one WIDTH+1 bit
// adder/subtractor and an iteration counter, used for both MUL and DIV.
module mul_div_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic                 step_i,
  input  iter_mode_e           mode_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_sub;
  logic [WIDTH+1:0]   add_res;

  assign hi = acc_q[2*WIDTH-1:WIDTH];
  assign lo = acc_q[WIDTH-1:0];

  // MUL adds the multiplicand into the high half when the multiplier LSB is
  // set; DIV trial-subtracts the divisor from the partial remainder shifted
  // left by one with the next dividend bit.
  always_comb begin
    add_sub = (mode_i == MODE_DIV);
    if (add_sub) begin
      add_x = {hi, lo[WIDTH-1]};
      add_y = {1'b0, b_q};
    end else begin
      add_x = {1'b0, hi};
      add_y = lo[0] ? {1'b0, b_q} : '0;
    end
  end

  assign add_res = {1'b0, add_x}
                 + {1'b0, (add_sub ? ~add_y : add_y)}
                 + {{(WIDTH+1){1'b0}}, add_sub};

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, a_i};
      b_d   = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (mode_i == MODE_MUL) begin
        acc_d = {add_res[WIDTH:0], lo[WIDTH-1:1]};
      end else if (add_res[WIDTH+1]) begin
        // Carry out of the subtract means no borrow: keep the difference.
        acc_d = {add_res[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {hi[WIDTH-2:0], lo, 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/seq_word_calculator.sv
// WIDTH-bit four-function calculator with clear; ADD/SUB/CLEAR finish in one
// cycle, MUL/DIV run WIDTH iterations on the shared mul_div_iter datapath.
module seq_word_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seq_word_calculator_if.slave  bus,
  output calc_state_e           state_o
);

  calc_state_e          state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 dbz_q, dbz_d;
  logic                 done_q, done_d;

  logic                 iter_load, iter_step, iter_last;
  iter_mode_e           iter_mode;
  logic [2*WIDTH-1:0]   iter_acc;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     sub_diff;

  assign add_sum   = {1'b0, a_q} + {1'b0, b_q};
  assign sub_diff  = a_q - b_q;
  assign iter_mode = (op_q == OP_DIV) ? MODE_DIV : MODE_MUL;

  mul_div_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (iter_load),
    .step_i  (iter_step),
    .mode_i  (iter_mode),
    .a_i     (bus.operand_a),
    .b_i     (bus.operand_b),
    .acc_o   (iter_acc),
    .last_o  (iter_last)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    iter_load = 1'b0;
    iter_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && op_is_valid(bus.op)) begin
          a_d  = bus.operand_a;
          b_d  = bus.operand_b;
          op_d = bus.op;
          if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.operand_b != '0)) begin
            state_d   = ST_ITER;
            iter_load = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        carry_d = 1'b0;
        dbz_d   = 1'b0;
        case (op_q)
          OP_ADD: begin
            result_d = {{(WIDTH-1){1'b0}}, add_sum};
            carry_d  = add_sum[WIDTH];
          end
          OP_SUB: begin
            result_d = {{WIDTH{1'b0}}, sub_diff};
            carry_d  = (a_q < b_q);
          end
          OP_DIV: begin
            // Only divide-by-zero reaches EXEC with a DIV op code.
            result_d = {a_q, {WIDTH{1'b1}}};
            dbz_d    = 1'b1;
          end
          default: result_d = '0;
        endcase
      end
      ST_ITER: begin
        if (iter_last) state_d = ST_FINISH;
        else           iter_step = 1'b1;
      end
      ST_FINISH: begin
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        result_d = iter_acc;
        carry_d  = 1'b0;
        dbz_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_CLEAR;
      result_q <= '0;
      carry_q  <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.div_by_zero = dbz_q;
  assign state_o         = state_q;

endmodule
